// File: rtl/lane_flash_ctrl_pkg.sv
// Shared types for the lane flash controller: lane states, one-hot level codes, state decode.
package lane_flash_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_L2  = 2'd1,
        ST_L1  = 2'd2,
        ST_L0  = 2'd3
    } lane_state_t;

    localparam logic [2:0] LVL_OFF = 3'b000;
    localparam logic [2:0] LVL_2   = 3'b100;
    localparam logic [2:0] LVL_1   = 3'b010;
    localparam logic [2:0] LVL_0   = 3'b001;

    function automatic logic [2:0] level_decode(input lane_state_t st);
        logic [2:0] lvl;
        case (st)
            ST_L2:   lvl = LVL_2;
            ST_L1:   lvl = LVL_1;
            ST_L0:   lvl = LVL_0;
            default: lvl = LVL_OFF;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/lane_flash_ctrl_btn_debounce.sv
// Single-lane button conditioner: 2-flop synchronizer, stability counter, registered press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic iVGA_CLK,
    input  logic iRST,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic             db_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronize, count consecutive disagreeing cycles, flip on terminal count, pulse on rise.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            db_r      <= 1'b0;
            db_prev_r <= 1'b0;
            cnt_r     <= '0;
            press_r   <= 1'b0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            db_prev_r <= db_r;
            press_r   <= db_r & ~db_prev_r;
            if (sync2_r != db_r) begin
                if (cnt_r == CNT_TERM) begin
                    db_r  <= sync2_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = db_r;
    assign press = press_r;

endmodule

// File: rtl/lane_flash_ctrl.sv
// Per-lane decaying highlight generator stepped on frame boundaries.
// Optional macro LANE_FLASH_HOLD_EN: a held button freezes a lane in L2 until release.
module lane_flash_ctrl
    import lane_flash_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_FRAMES     = 4
) (
    input  logic                   iVGA_CLK,
    input  logic                   iRST,
    input  logic [NUM_LANES-1:0]   iBTN,
    input  logic                   iVS,
    output logic [3*NUM_LANES-1:0] oLEVEL,
    output logic [NUM_LANES-1:0]   oPRESS,
    output logic                   oFRAME_TICK
);

    localparam int FCNT_W = $clog2(HOLD_FRAMES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_TERM = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

`ifdef LANE_FLASH_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    logic [NUM_LANES-1:0]   db_s;
    logic [NUM_LANES-1:0]   press_s;
    logic [NUM_LANES-1:0]   hold_s;
    logic [NUM_LANES-1:0]   pending_r;
    logic [NUM_LANES-1:0]   pend_nxt_s;
    lane_state_t            state_r    [NUM_LANES];
    lane_state_t            state_nxt_s[NUM_LANES];
    logic [FCNT_W-1:0]      fcnt_r     [NUM_LANES];
    logic [FCNT_W-1:0]      fcnt_nxt_s [NUM_LANES];
    logic                   vs_prev_r;
    logic                   tick_r;
    logic [3*NUM_LANES-1:0] level_r;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .iVGA_CLK(iVGA_CLK),
            .iRST    (iRST),
            .btn     (iBTN[g]),
            .level   (db_s[g]),
            .press   (press_s[g])
        );
    end

    assign hold_s = db_s & {NUM_LANES{HOLD_EN}};

    // Frame tick: registered iVS falling-edge detect.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            vs_prev_r <= 1'b1;
            tick_r    <= 1'b0;
        end else begin
            vs_prev_r <= iVS;
            tick_r    <= vs_prev_r & ~iVS;
        end
    end

    // Lane next-state: a press arriving with the tick still counts for that tick.
    always_comb begin
        for (int n = 0; n < NUM_LANES; n++) begin
            state_nxt_s[n] = state_r[n];
            fcnt_nxt_s[n]  = fcnt_r[n];
            pend_nxt_s[n]  = pending_r[n] | press_s[n];
            if (tick_r) begin
                pend_nxt_s[n] = 1'b0;
                if (pending_r[n] | press_s[n]) begin
                    state_nxt_s[n] = ST_L2;
                    fcnt_nxt_s[n]  = '0;
                end else begin
                    case (state_r[n])
                        ST_L2: begin
                            if (hold_s[n]) begin
                                fcnt_nxt_s[n] = '0;
                            end else if (fcnt_r[n] == FCNT_TERM) begin
                                state_nxt_s[n] = ST_L1;
                                fcnt_nxt_s[n]  = '0;
                            end else begin
                                fcnt_nxt_s[n] = fcnt_r[n] + FCNT_ONE;
                            end
                        end
                        ST_L1: begin
                            if (fcnt_r[n] == FCNT_TERM) begin
                                state_nxt_s[n] = ST_L0;
                                fcnt_nxt_s[n]  = '0;
                            end else begin
                                fcnt_nxt_s[n] = fcnt_r[n] + FCNT_ONE;
                            end
                        end
                        ST_L0: begin
                            if (fcnt_r[n] == FCNT_TERM) begin
                                state_nxt_s[n] = ST_OFF;
                                fcnt_nxt_s[n]  = '0;
                            end else begin
                                fcnt_nxt_s[n] = fcnt_r[n] + FCNT_ONE;
                            end
                        end
                        default: begin
                            state_nxt_s[n] = ST_OFF;
                            fcnt_nxt_s[n]  = '0;
                        end
                    endcase
                end
            end else begin
                state_nxt_s[n] = state_r[n];
            end
        end
    end

    // Lane state, counters, pending flags and the tick-aligned level register.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            pending_r <= '0;
            level_r   <= '0;
            for (int n = 0; n < NUM_LANES; n++) begin
                state_r[n] <= ST_OFF;
                fcnt_r[n]  <= '0;
            end
        end else begin
            pending_r <= pend_nxt_s;
            for (int n = 0; n < NUM_LANES; n++) begin
                state_r[n] <= state_nxt_s[n];
                fcnt_r[n]  <= fcnt_nxt_s[n];
                if (tick_r) begin
                    level_r[3*n +: 3] <= level_decode(state_nxt_s[n]);
                end
            end
        end
    end

    assign oLEVEL      = level_r;
    assign oPRESS      = press_s;
    assign oFRAME_TICK = tick_r;

endmodule

// File: doc/lane_flash_ctrl.md
Name: lane_flash_ctrl

Overview:
- Sits directly upstream of the VGA display controller and produces its per-lane 3-bit highlight input; lane 0 drives in_left.
- Debounces raw player buttons and turns each accepted press into a decaying flash: level 2 (darkest), then level 1, then level 0, then off.
- Steps between levels only on frame boundaries, so a highlight never changes mid-frame and the display never tears.

Parameters:
- NUM_LANES, 4: number of independent button/highlight lanes.
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks (10 ms at 25 MHz) before a new button level is accepted.
- HOLD_FRAMES, 4: frame ticks spent at each flash level; must be at least 1.

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock.
- iRST  in  1  synchronous reset, active-high.
- iBTN  in  NUM_LANES  raw asynchronous buttons, 1 = pressed.
- iVS  in  1  active-low vertical sync from the sync generator, same clock domain.
- oLEVEL  out  3*NUM_LANES  per-lane one-hot level; lane n uses bits [3n+2:3n]; 100 = level 2, 010 = level 1, 001 = level 0, 000 = off.
- oPRESS  out  NUM_LANES  one-cycle pulse on each accepted press.
- oFRAME_TICK  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (iRST sampled high on an edge):
  - oLEVEL = 0, oPRESS = 0, oFRAME_TICK = 0.
  - Debounced state = released; debounce and frame counters = 0; pending flags cleared; every lane FSM in OFF.
  - Reset takes effect mid-flash or mid-debounce alike.
- Input sync: each iBTN bit passes through a 2-flop synchronizer.
- Debounce (per lane):
  - Counter increments while the synchronized value differs from the debounced state.
  - Counter clears to 0 when the two values match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- Press detect:
  - A debounced 0->1 transition asserts oPRESS[n] for exactly one cycle, one clock after the flip.
  - The same event sets pending[n].
  - Releases generate nothing.
- Frame tick:
  - Fires on an iVS falling edge, detected with a one-flop history of iVS (reset value 1).
  - oFRAME_TICK is high the cycle after iVS is first sampled 0.
- Lane FSM states: OFF, L2, L1, L0. State and counter are evaluated only in the cycle oFRAME_TICK is high.
  - Any state with pending set: go to L2, clear frame counter, clear pending. A re-press therefore restarts the flash.
  - L2/L1/L0 without pending: if frame counter = HOLD_FRAMES-1, advance L2->L1->L0->OFF and clear the counter; otherwise increment the counter.
  - OFF without pending: stay in OFF.
- Simultaneous events:
  - A press pulse in the same cycle as the tick counts as pending for that tick.
  - Multiple presses between ticks collapse to one.
- Output timing:
  - oLEVEL is registered and decoded from FSM state.
  - oLEVEL changes exactly 1 clock after oFRAME_TICK and never at any other time.
- Width rules:
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES); frame counter width is $clog2(HOLD_FRAMES)+1.
  - Neither counter wraps; both clear at terminal count.

Optional Feature:
- LANE_FLASH_HOLD_EN defined:
  - While the debounced button stays pressed, a lane in L2 does not advance and its frame counter is held at 0.
  - Decay begins at the first tick after release.
- Not defined: decay proceeds regardless of button state, as described above.

Decomposition:
- Package lane_flash_pkg holds:
  - lane state enum (OFF, L2, L1, L0);
  - level encoding constants LVL_OFF = 3'b000, LVL_2 = 3'b100, LVL_1 = 3'b010, LVL_0 = 3'b001;
  - a state-to-level decode function.
- One sub-module, btn_debounce: synchronizer, debounce counter and rising-edge pulse for a single lane, generated NUM_LANES times.
- Frame tick detection and the lane FSMs stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_FRAMES=2, NUM_LANES=4):
- Reset, no stimulus, 3 frames -> oLEVEL = 12'h000 and oPRESS = 0 throughout; oFRAME_TICK pulses once per iVS falling edge.
- iBTN[0] high 3 cycles then low -> no oPRESS, oLEVEL stays 0 (glitch rejected).
- iBTN[0] held high 10 cycles -> single oPRESS[0] pulse, then:
  - next tick: oLEVEL[2:0] = 100;
  - 2 ticks later: 010;
  - 2 later: 001;
  - 2 later: 000.
- Press lane 2 while lane 2 is in L1 -> next tick: oLEVEL[8:6] = 100 and the counter restarts; other lanes unaffected.
- Press pulse coincident with oFRAME_TICK -> oLEVEL goes to 100 one clock later; iRST asserted mid-L2 -> oLEVEL = 0 on the next clock and the pending press is discarded.
- With LANE_FLASH_HOLD_EN, hold iBTN[1] for 6 frames -> oLEVEL[5:3] stays 100; after release, 010 appears 2 ticks later.
